// File: rtl/seq_det_pkg.sv
// Shared reset defaults and width helper for the parameterised serial pattern detector.
package seq_det_pkg;

   localparam logic [15:0] DEF_RST_PATTERN = 16'b10010;
   localparam int          DEF_RST_LEN     = 5;
   localparam bit          DEF_RST_OVERLAP = 1'b1;

   // Width able to hold every length from 0 up to and including max_len.
   function automatic int len_w(input int max_len);
      return $clog2(max_len) + 1;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; a clear coinciding with an increment yields 1.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         q <= '0;
      end else if (clr) begin
         q <= W'(inc);
      end else if (inc && (q != '1)) begin
         q <= q + W'(1);
      end
   end

endmodule

// File: rtl/seq_detector_param.sv
// Run-time configurable serial pattern detector: Mealy decision on the current bit,
// registered one-cycle match pulse, optional overlap, saturating match counter.
module seq_detector_param
   import seq_det_pkg::*;
#(
   parameter int          MAX_LEN     = 8,
   parameter int          CNT_W       = 8,
   parameter logic [15:0] RST_PATTERN = DEF_RST_PATTERN,
   parameter int          RST_LEN     = DEF_RST_LEN,
   parameter bit          RST_OVERLAP = DEF_RST_OVERLAP,
   localparam int         LEN_W       = len_w(MAX_LEN)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cfg_we,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   input  logic               in_valid,
   input  logic               x,
   input  logic               count_clr,
   output logic               y,
   output logic [CNT_W-1:0]   match_count,
   output logic [LEN_W-1:0]   cfg_len_q
);

   localparam logic [LEN_W-1:0] FILL_MAX  = LEN_W'(MAX_LEN);
   localparam logic [LEN_W-1:0] RST_LEN_C = (RST_LEN > MAX_LEN) ? LEN_W'(MAX_LEN) : LEN_W'(RST_LEN);

   logic [MAX_LEN-1:0] pattern_q;
   logic [LEN_W-1:0]   len_q;
   logic               overlap_q;
   logic [MAX_LEN-1:0] hist_q;
   logic [LEN_W-1:0]   fill_q;
   logic               y_q;

   logic [MAX_LEN-1:0] window;
   logic [MAX_LEN-1:0] mask;
   logic [LEN_W:0]     fill_inc;
   logic               match;

   function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
      return (int'(l) > MAX_LEN) ? FILL_MAX : l;
   endfunction

   assign window   = {hist_q[MAX_LEN-2:0], x};
   assign fill_inc = {1'b0, fill_q} + (LEN_W+1)'(1);

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      mask = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         mask[i] = (i < int'(len_q));
      end
   end

   // A configuration write in the same cycle discards the bit, so it can never match.
   assign match = in_valid && !cfg_we && (len_q != '0) &&
                  (fill_inc >= {1'b0, len_q}) &&
                  (((window ^ pattern_q) & mask) == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         pattern_q <= RST_PATTERN[MAX_LEN-1:0];
         len_q     <= RST_LEN_C;
         overlap_q <= RST_OVERLAP;
         hist_q    <= '0;
         fill_q    <= '0;
         y_q       <= 1'b0;
      end else begin
         y_q <= match;
         if (cfg_we) begin
            pattern_q <= cfg_pattern;
            len_q     <= clamp_len(cfg_len);
            overlap_q <= cfg_overlap;
            hist_q    <= '0;
            fill_q    <= '0;
         end else if (in_valid) begin
            hist_q <= window;
            if (match && !overlap_q) begin
               fill_q <= '0;
            end else if (fill_q != FILL_MAX) begin
               fill_q <= fill_q + LEN_W'(1);
            end
         end
      end
   end

   sat_counter #(
      .W(CNT_W)
   ) u_count (
      .clk  (clk),
      .reset(reset),
      .clr  (count_clr),
      .inc  (match),
      .q    (match_count)
   );

   assign y         = y_q;
   assign cfg_len_q = len_q;

endmodule
